pwm_multichannel: RTL and testbench
===================================

Name: pwm_multichannel

Overview:
Parametrised multi-channel PWM generator. It replaces the fixed 16-channel, 8-bit PWM peripheral behind the SPI register file. Adds a programmable period (top), a clock prescaler, edge/center-aligned modes, and double-buffered per-channel duty cycles that update glitch-free at period boundaries. The register file drives its write port and enables; its outputs go to the uo_out/uio_out pins.

Parameters:
NUM_CH, 16, number of PWM channels
CNT_W, 8, counter, top and duty width in bits
PRESC_W, 8, prescaler width in bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
run  in  1  1 = timebase counts; 0 = timebase held at 0
mode  in  1  0 = edge-aligned, 1 = center-aligned (shadowed)
top  in  CNT_W  counter terminal value (shadowed)
prescale  in  PRESC_W  count tick every prescale+1 clocks (shadowed)
wr_en  in  1  duty write strobe
wr_ch  in  $clog2(NUM_CH)  channel index for write
wr_duty  in  CNT_W  duty value
en_out  in  NUM_CH  per-channel output enable, applied immediately
en_pwm  in  NUM_CH  per-channel PWM enable (0 = static high when en_out=1), applied immediately
out  out  NUM_CH  registered PWM outputs
period_end  out  1  one-clock pulse at each period boundary

Behaviour:
- Reset (rst=1 at a clk edge):
  - cnt, presc_cnt, duty_shadow[], duty_act[], out and period_end all go to 0.
  - Direction goes to up. Active mode/top/prescale go to 0.
  - Reset mid-period aborts the period immediately. No period_end pulse is issued.
- Write:
  - wr_en=1 with wr_ch<NUM_CH sets duty_shadow[wr_ch]=wr_duty on the next edge.
  - wr_ch>=NUM_CH is ignored.
- Prescaler:
  - presc_cnt counts 0..prescale_act, then wraps.
  - tick=1 when presc_cnt==prescale_act. prescale_act=0 gives a tick every clock.
- Edge mode:
  - On each tick, cnt goes 0,1..top_act, then wraps to 0.
  - Boundary = tick with cnt==top_act. Period = (top_act+1) ticks.
- Center mode:
  - On each tick, cnt goes 0,1..top_act,top_act,top_act-1..0,0.
  - At top_act: the value is held one tick and direction flips to down.
  - At 0 while down: the value is held one tick, direction flips to up, and this is the boundary.
  - Period = 2*(top_act+1) ticks.
- At a boundary, on the same edge:
  - period_end=1 for exactly one clock.
  - duty_act[i] loads duty_shadow[i]. If a write to channel i occurs in the same cycle, wr_duty is loaded directly (bypass).
  - mode/top/prescale are latched into their _act registers.
- run=0:
  - cnt, presc_cnt and direction are held at reset values. No period_end.
  - Shadows are copied to active every cycle, with the same bypass rule.
  - The PWM compare result is forced to 0.
- Compare, per channel:
  - pwm[i] = (cnt < duty_act[i]).
  - duty_act = 2^CNT_W-1 forces pwm high. duty_act = 0 gives pwm low always.
  - duty_act > top_act gives pwm high for the whole period.
- Output:
  - out[i] <= en_out[i] & (en_pwm[i] ? pwm[i] : 1), registered.
  - Latency: one clock from the cnt value to out.
  - Enable changes take effect on the next edge, not at the boundary.
- Changing mode/top/prescale mid-period has no effect until the next boundary.
- Center mode with top_act=2^CNT_W-1 is legal. There is no wrap, because the count turns around at top_act.

Decomposition:
- Package pwm_pkg: mode encodings MODE_EDGE=1'b0 and MODE_CENTER=1'b1; DIR_UP/DIR_DOWN; default parameter constants.
- Sub-module pwm_timebase: prescaler, counter, direction flag, boundary detect, period_end, and the _act latches for mode/top/prescale.
- The top level instantiates pwm_timebase and generates NUM_CH compare/shadow/output slices.

Test Plan:
- Reset: hold rst=1 for 2 clocks with writes pending -> out=0, period_end=0, cnt=0. Release -> first period_end after (top+1)*(prescale+1) clocks.
- Edge mode, top=255, prescale=0, duty ch0=64, en_out=en_pwm=all 1 -> out[0] high 64 of every 256 clocks; period_end every 256 clocks.
- Shadow update: write ch0=128 at cnt=100 -> ch0 stays at 64 high clocks for the current period, 128 from the next period. Write in the same cycle as the boundary -> the new value is used in the next period.
- Center mode, top=9, duty ch1=4 -> period 20 ticks, out[1] high 8 clocks centred on the cnt=0 boundary; period_end every 20 clocks.
- Prescale=3, edge, top=255 -> each count lasts 4 clocks; period_end every 1024 clocks.
- Corners:
  - duty=255 -> constant high; duty=0 -> constant low.
  - en_pwm=0, en_out=1 -> high.
  - en_out=0 -> low on the next clock.
  - run=0 mid-period -> cnt=0, PWM outputs low, no period_end.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared encodings and default sizes for the multi-channel PWM
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int DEF_NUM_CH  = 16;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_PRESC_W = 8;

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler, up/up-down counter, boundary detect and shadowed timing parameters
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               mode,
  input  logic [CNT_W-1:0]   top,
  input  logic [PRESC_W-1:0] prescale,
  output logic [CNT_W-1:0]   cnt,
  output logic               load,
  output logic               period_end
);

  logic [PRESC_W-1:0] presc_cnt;
  logic [PRESC_W-1:0] prescale_act;
  logic [CNT_W-1:0]   top_act;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               mode_act;
  logic               tick;
  logic               boundary;
  dir_t               dir;
  dir_t               dir_nxt;

  always_comb begin
    tick     = (presc_cnt == prescale_act);
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    boundary = 1'b0;
    if (tick) begin
      if (mode_act == MODE_EDGE) begin
        if (cnt == top_act) begin
          cnt_nxt  = '0;
          boundary = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else if (dir == DIR_UP) begin
        // Turnaround holds the peak value for one extra tick, so top_act = all-ones never wraps.
        if (cnt == top_act) dir_nxt = DIR_DOWN;
        else                cnt_nxt = cnt + 1'b1;
      end else begin
        if (cnt == '0) begin
          dir_nxt  = DIR_UP;
          boundary = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
    end
    // While idle the duty and timing shadows are transparent.
    load = !run || boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt    <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      period_end   <= 1'b0;
      mode_act     <= MODE_EDGE;
      top_act      <= '0;
      prescale_act <= '0;
    end else if (!run) begin
      presc_cnt    <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      period_end   <= 1'b0;
      mode_act     <= mode;
      top_act      <= top;
      prescale_act <= prescale;
    end else begin
      presc_cnt  <= tick ? '0 : presc_cnt + 1'b1;
      cnt        <= cnt_nxt;
      dir        <= dir_nxt;
      period_end <= boundary;
      if (boundary) begin
        mode_act     <= mode;
        top_act      <= top;
        prescale_act <= prescale;
      end
    end
  end

endmodule

// File: rtl/pwm_multichannel.sv
// rtl/pwm_multichannel.sv - parametrised PWM generator with double-buffered per-channel duty
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      mode,
  input  logic [CNT_W-1:0]          top,
  input  logic [PRESC_W-1:0]        prescale,
  input  logic                      wr_en,
  input  logic [$clog2(NUM_CH)-1:0] wr_ch,
  input  logic [CNT_W-1:0]          wr_duty,
  input  logic [NUM_CH-1:0]         en_out,
  input  logic [NUM_CH-1:0]         en_pwm,
  output logic [NUM_CH-1:0]         out,
  output logic                      period_end
);

  localparam int              CH_W     = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] DUTY_MAX = '1;

  logic [CNT_W-1:0] cnt;
  logic             load;

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mode       (mode),
    .top        (top),
    .prescale   (prescale),
    .cnt        (cnt),
    .load       (load),
    .period_end (period_end)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_shadow;
    logic [CNT_W-1:0] duty_act;
    logic             wr_hit;
    logic             pwm;
    logic             out_q;

    // Indices with no matching slice simply fall through, which drops out-of-range writes.
    assign wr_hit = wr_en && (wr_ch == CH_W'(i));
    assign pwm    = run && ((duty_act == DUTY_MAX) || (cnt < duty_act));
    assign out[i] = out_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        duty_shadow <= '0;
        duty_act    <= '0;
        out_q       <= 1'b0;
      end else begin
        if (wr_hit) duty_shadow <= wr_duty;
        if (load)   duty_act    <= wr_hit ? wr_duty : duty_shadow;
        out_q <= en_out[i] & (en_pwm[i] ? pwm : 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb/tb_pwm_multichannel.sv - directed self-checking bench for pwm_multichannel
module tb_pwm_multichannel;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        mode;
  logic [7:0]  top;
  logic [7:0]  prescale;
  logic        wr_en;
  logic [3:0]  wr_ch;
  logic [7:0]  wr_duty;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out;
  logic        period_end;

  int          n_vec = 0;
  int          n_err = 0;
  int          highs[16];
  logic [31:0] pat1;
  int          len;
  int          pe_seen;

  always #5 clk = ~clk;

  pwm_multichannel dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mode       (mode),
    .top        (top),
    .prescale   (prescale),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_duty    (wr_duty),
    .en_out     (en_out),
    .en_pwm     (en_pwm),
    .out        (out),
    .period_end (period_end)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_duty(input logic [3:0] ch, input logic [7:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_duty = d;
    step();
    wr_en = 1'b0;
  endtask

  // Runs until period_end is seen (or budget expires, giving len=-1); optional write before edge wr_at.
  task automatic measure(input int budget, input int wr_at, input logic [3:0] wch,
                         input logic [7:0] wd);
    len  = -1;
    pat1 = '0;
    for (int c = 0; c < 16; c++) highs[c] = 0;
    for (int n = 0; n < budget; n++) begin
      if (n == wr_at) begin
        wr_en = 1'b1; wr_ch = wch; wr_duty = wd;
      end
      step();
      wr_en = 1'b0;
      for (int c = 0; c < 16; c++) if (out[c]) highs[c]++;
      pat1 = {pat1[30:0], out[1]};
      if (period_end) begin
        len = n + 1;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mode = 1'b0; top = 8'd255; prescale = 8'd0;
    wr_en = 1'b1; wr_ch = 4'd0; wr_duty = 8'd64;
    en_out = ~16'h0020; en_pwm = ~16'h0010;

    step();
    step();
    check("reset_out", int'(out), 0);
    check("reset_period_end", int'(period_end), 0);
    check("reset_cnt", int'(dut.u_timebase.cnt), 0);

    rst = 1'b0;
    step();
    wr_en = 1'b0;
    write_duty(4'd1, 8'd4);
    write_duty(4'd2, 8'd255);
    write_duty(4'd3, 8'd0);

    run = 1'b1;
    measure(400, -1, 4'd0, 8'd0);
    check("first_period_end", len, 256);

    measure(400, -1, 4'd0, 8'd0);
    check("edge_period", len, 256);
    check("edge_ch0_duty64", highs[0], 64);
    check("edge_ch1_duty4", highs[1], 4);
    check("edge_ch2_duty255", highs[2], 256);
    check("edge_ch3_duty0", highs[3], 0);
    check("edge_ch4_en_pwm0", highs[4], 256);
    check("edge_ch5_en_out0", highs[5], 0);

    measure(400, 100, 4'd0, 8'd128);
    check("shadow_cur_period", highs[0], 64);
    measure(400, 255, 4'd0, 8'd200);
    check("shadow_next_period", highs[0], 128);
    check("shadow_next_len", len, 256);
    measure(400, -1, 4'd0, 8'd0);
    check("boundary_bypass", highs[0], 200);

    en_out[2] = 1'b0;
    step();
    check("en_out_off_next_clk", int'(out[2]), 0);
    en_out[2] = 1'b1;
    step();
    check("en_out_on_next_clk", int'(out[2]), 1);

    run = 1'b0;
    pe_seen = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (period_end) pe_seen++;
    end
    check("idle_no_period_end", pe_seen, 0);
    check("idle_cnt", int'(dut.u_timebase.cnt), 0);
    check("idle_ch0_low", int'(out[0]), 0);
    check("idle_ch2_low", int'(out[2]), 0);
    check("idle_ch4_static_high", int'(out[4]), 1);

    prescale = 8'd3;
    step();
    run = 1'b1;
    measure(2000, -1, 4'd0, 8'd0);
    check("presc3_first_period", len, 1024);
    prescale = 8'd0;
    measure(2000, -1, 4'd0, 8'd0);
    check("presc3_shadowed_period", len, 1024);
    check("presc3_ch0_highs", highs[0], 800);
    measure(2000, -1, 4'd0, 8'd0);
    check("presc0_after_boundary", len, 256);

    run = 1'b0; mode = 1'b1; top = 8'd9;
    step();
    run = 1'b1;
    measure(100, -1, 4'd0, 8'd0);
    check("center_first_period", len, 20);
    measure(100, -1, 4'd0, 8'd0);
    check("center_period", len, 20);
    check("center_ch1_highs", highs[1], 8);
    check("center_ch1_pattern", int'(pat1[19:0]), 32'h000F000F);
    check("center_ch0_duty_gt_top", highs[0], 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
